// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/writeback bundle between the core and the muldiv unit
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_index;
  logic        busy;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_index,
    input  busy, reg_write, write_index, write_data
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_index,
    output busy, reg_write, write_index, write_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed 34-cycle latency
module muldiv_unit (
  input  logic          clk,
  input  logic          nRST,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [2:0]  op;
  logic [4:0]  rd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] bmag;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero;
  logic        ovf;
  logic        busy_r;
  logic        reg_write_r;
  logic [4:0]  write_index_r;
  logic [31:0] write_data_r;

  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [63:0] product, prod_s;
  logic [31:0] quot, remv, result;

  // Operand signedness: DIV/REM signed, DIVU/REMU unsigned; MUL/MULH signed, MULHSU A-only.
  always_comb begin
    a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg    = a_signed & bus.rs1_data[31];
    b_neg    = b_signed & bus.rs2_data[31];
    a_abs    = a_neg ? -bus.rs1_data : bus.rs1_data;
    b_abs    = b_neg ? -bus.rs2_data : bus.rs2_data;
  end

  // hi:lo is the product for multiplies and remainder:quotient for divides.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, bmag} : 33'd0);
    shifted = {hi, lo[31]};
    diff    = {1'b0, shifted} - {2'b00, bmag};
    product = {hi, lo};
    prod_s  = neg_q ? -product : product;
    quot    = neg_q ? -lo : lo;
    remv    = neg_r ? -hi : hi;
    case (op)
      3'b000:  result = prod_s[31:0];
      3'b100:  result = div_zero ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : quot);
      3'b101:  result = div_zero ? 32'hFFFF_FFFF : lo;
      3'b110:  result = ovf ? 32'd0 : remv;
      3'b111:  result = hi;
      default: result = prod_s[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      count         <= 6'd0;
      op            <= 3'd0;
      rd            <= 5'd0;
      hi            <= 32'd0;
      lo            <= 32'd0;
      bmag          <= 32'd0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div_zero      <= 1'b0;
      ovf           <= 1'b0;
      busy_r        <= 1'b0;
      reg_write_r   <= 1'b0;
      write_index_r <= 5'd0;
      write_data_r  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            count    <= 6'd0;
            op       <= bus.funct3;
            rd       <= bus.rd_index;
            hi       <= 32'd0;
            lo       <= a_abs;
            bmag     <= b_abs;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= bus.funct3[2] & (bus.rs2_data == 32'd0);
            ovf      <= bus.funct3[2] & ~bus.funct3[0] &
                        (bus.rs1_data == 32'h8000_0000) & (bus.rs2_data == 32'hFFFF_FFFF);
            busy_r   <= 1'b1;
          end
        end
        RUN: begin
          if (!count[5]) begin
            count <= count + 6'd1;
            if (op[2]) begin
              if (!diff[33]) begin
                hi <= diff[31:0];
                lo <= {lo[30:0], 1'b1};
              end else begin
                hi <= shifted[31:0];
                lo <= {lo[30:0], 1'b0};
              end
            end else begin
              hi <= mul_sum[32:1];
              lo <= {mul_sum[0], lo[31:1]};
            end
          end else begin
            // All 32 iterations finished: sign-fix, override and publish in one step.
            state         <= DONE;
            write_data_r  <= result;
            write_index_r <= rd;
            reg_write_r   <= (rd != 5'd0);
          end
        end
        DONE: begin
          state       <= IDLE;
          reg_write_r <= 1'b0;
          busy_r      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.reg_write   = reg_write_r;
  assign bus.write_index = write_index_r;
  assign bus.write_data  = write_data_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  logic clk;
  logic nRST;
  int   checks;
  int   errors;

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural result computed with wide signed/unsigned arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'sd0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op and watch 36 cycles after the accept edge; optionally pulse start at cycle inject_k.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int inject_k);
    int busy_bad;
    int wr_cnt;
    int wr_k;
    busy_bad = 0;
    wr_cnt   = 0;
    wr_k     = -1;
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_index = rd;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.funct3   = 3'($urandom);
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    bus.rd_index = 5'($urandom);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (bus.busy !== (k <= 33)) busy_bad++;
      if (bus.reg_write === 1'b1) begin
        wr_cnt++;
        wr_k = k;
      end
      if (k == inject_k) begin
        bus.start    = 1'b1;
        bus.funct3   = 3'($urandom);
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.rd_index = 5'd9;
      end else begin
        bus.start = 1'b0;
      end
    end
    check({name, "/busy_profile"}, 32'(busy_bad), 32'd0);
    check({name, "/write_pulses"}, 32'(wr_cnt), (rd != 5'd0) ? 32'd1 : 32'd0);
    if (rd != 5'd0) check({name, "/write_cycle"}, 32'(wr_k), 32'd33);
    check({name, "/write_data"}, bus.write_data, exp);
    check({name, "/write_index"}, 32'(bus.write_index), 32'(rd));
  endtask

  initial begin
    int wr;
    int busy_seen;
    checks = 0;
    errors = 0;

    tbl[0]  = '{"mul_neg",      3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    tbl[1]  = '{"mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000};
    tbl[2]  = '{"mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
    tbl[3]  = '{"mulhsu_max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
    tbl[4]  = '{"div_neg",      3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD};
    tbl[5]  = '{"rem_neg",      3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF};
    tbl[6]  = '{"divu",         3'd5, 32'd100,       32'd7,         5'd7,  32'd14};
    tbl[7]  = '{"remu",         3'd7, 32'd100,       32'd7,         5'd8,  32'd2};
    tbl[8]  = '{"divu_by0",     3'd5, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF};
    tbl[9]  = '{"rem_by0",      3'd6, 32'd5,         32'd0,         5'd11, 32'd5};
    tbl[10] = '{"div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000};
    tbl[11] = '{"rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0};
    tbl[12] = '{"mul_rd0",      3'd0, 32'd3,         32'd4,         5'd0,  32'd12};

    nRST         = 1'b0;
    bus.start    = 1'b0;
    bus.funct3   = 3'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    bus.rd_index = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/reg_write", 32'(bus.reg_write), 32'd0);
    check("reset/write_index", 32'(bus.write_index), 32'd0);
    check("reset/write_data", bus.write_data, 32'd0);
    nRST = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].name, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, -1);

    run_op("ignored_start", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 10);

    // Reset during RUN: outputs clear at once and the aborted op never writes back.
    bus.start    = 1'b1;
    bus.funct3   = 3'd5;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    bus.rd_index = 5'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    nRST = 1'b0;
    #1;
    check("midreset/busy", 32'(bus.busy), 32'd0);
    check("midreset/reg_write", 32'(bus.reg_write), 32'd0);
    check("midreset/write_index", 32'(bus.write_index), 32'd0);
    check("midreset/write_data", bus.write_data, 32'd0);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    wr = 0;
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.reg_write === 1'b1) wr++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    check("midreset/no_write", 32'(wr), 32'd0);
    check("midreset/stays_idle", 32'(busy_seen), 32'd0);
    run_op("after_reset_mul", 3'd0, 32'd6, 32'd7, 5'd3, 32'd42, -1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      rd = 5'($urandom_range(1, 31));
      run_op("random", f3, a, b, rd, ref_model(f3, a, b), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
